// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// Optional write-to-read forwarding is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 16;
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    // Wide result; callers truncate to their own register width.
    function automatic longint unsigned init_value(
        input int unsigned idx,
        input int unsigned step
    );
        return 64'(idx) * 64'(step);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Pending-write tracker: reservations set a bit, write-back clears it.
// Also owns the reservation ack, stray-write error pulse and pending count.
module regfile_scoreboard_sb
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              rsv_ack,
    output logic [NUM_REGS-1:0] pending,
    output logic              wr_err,
    output logic [ADDR_W:0]   pend_cnt
);

    logic rsv_set;
    logic wr_hit;
    logic clr_valid;

    assign rsv_ack   = rsv_valid && (rsv_addr == '0 || !pending[rsv_addr]);
    assign rsv_set   = rsv_ack && rsv_addr != '0;
    assign wr_hit    = wr_en && wr_addr != '0;
    assign clr_valid = wr_hit && pending[wr_addr];

    // Clear before set: a fresh reservation outlives a same-cycle stray write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            wr_err   <= 1'b0;
            pend_cnt <= '0;
        end else begin
            wr_err <= wr_hit && !pending[wr_addr];
            if (wr_hit) pending[wr_addr] <= 1'b0;
            if (rsv_set) pending[rsv_addr] <= 1'b1;
            if (rsv_set && !clr_valid)
                pend_cnt <= pend_cnt + 1'b1;
            else if (clr_valid && !rsv_set)
                pend_cnt <= pend_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with N combinational read ports, one write port and a
// pending-write scoreboard. Define REGFILE_BYPASS_EN for write forwarding.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int NUM_RD    = 2,
    parameter int INIT_STEP = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ack,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_err,
    output logic [ADDR_W:0]          pend_cnt
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;

    // R0 is reset to zero and never written, so it reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= DATA_W'(init_value(i, INIT_STEP));
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        logic hit;
        assign hit = wr_en && wr_addr != '0 && addr == wr_addr;
        assign rd_data[k*DATA_W +: DATA_W] = hit ? wr_data : regs[addr];
        assign rd_busy[k] = pending[addr] && !hit;
`else
        assign rd_data[k*DATA_W +: DATA_W] = regs[addr];
        assign rd_busy[k] = pending[addr];
`endif
    end

    regfile_scoreboard_sb #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rsv_ack   (rsv_ack),
        .pending   (pending),
        .wr_err    (wr_err),
        .pend_cnt  (pend_cnt)
    );

endmodule
